// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell, time-shared across every bit of a serial operation.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_OVF_EN.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef SERIAL_OVF_EN
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);
`endif

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             load;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_nxt;
`ifdef SERIAL_OVF_EN
  logic             c_msb;
`endif

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    load = 1'b0;
    unique case (state)
      S_IDLE: load = start;
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        load = start;
      end
      default: ;
    endcase
  end

  // The low WIDTH-1 result bits live in res; the cell's current sum bit
  // completes the word on the final step.
  assign res_nxt = {fa_sum, res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_OVF_EN
      c_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      res   <= '0;
    end else if (state == S_RUN) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      res   <= res_nxt[WIDTH-1:1];
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
`ifdef SERIAL_OVF_EN
      if (cnt == CNT_PREV) c_msb <= fa_cout;
`endif
      if (cnt == CNT_LAST) begin
        sum  <= res_nxt;
        cout <= fa_cout;
`ifdef SERIAL_OVF_EN
        ovf  <= c_msb ^ fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at WIDTH=8.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
`ifdef SERIAL_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

`ifndef SERIAL_OVF_EN
  assign ovf = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_OVF_EN
    check(tag, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full single operation from IDLE; inputs are scrambled mid-run.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic [W-1:0] es, input logic ec, input logic eo);
    int busy_cnt;
    int done_seen;
    a = av; b = bv; sub = sv; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt  = int'(busy);
    done_seen = int'(done);
    for (int i = 1; i < W; i++) begin
      tick();
      if (i == 3) begin a = ~av; b = ~bv; sub = ~sv; start = 1'b1; end
      if (i == 4) start = 1'b0;
      busy_cnt  += int'(busy);
      done_seen += int'(done);
    end
    check({tag, ".busy_cycles"}, busy_cnt, W);
    check({tag, ".early_done"}, done_seen, 0);
    tick();
    check({tag, ".done"}, {31'd0, done}, 1);
    check({tag, ".busy_off"}, {31'd0, busy}, 0);
    check({tag, ".sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    check_ovf({tag, ".ovf"}, eo);
    tick();
    check({tag, ".done_pulse"}, {31'd0, done}, 0);
  endtask

  logic [W-1:0] ba  [3] = '{8'h12, 8'h50, 8'hC0};
  logic [W-1:0] bb  [3] = '{8'h34, 8'h30, 8'h80};
  logic         bs  [3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] bes [3] = '{8'h46, 8'h20, 8'h40};
  logic         bec [3] = '{1'b0, 1'b1, 1'b1};
  logic         beo [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick();
    check("reset.sum", {24'd0, sum}, 0);
    check("reset.cout", {31'd0, cout}, 0);
    check("reset.busy", {31'd0, busy}, 0);
    check("reset.done", {31'd0, done}, 0);
    check_ovf("reset.ovf", 1'b0);
    rst = 1'b0;
    tick();

    run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_20_10", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-to-back with start held; toggles and operand changes mid-run.
    a = ba[0]; b = bb[0]; sub = bs[0]; start = 1'b1;
    tick();
    for (int op = 0; op < 3; op++) begin
      check($sformatf("b2b%0d.busy", op), {31'd0, busy}, 1);
      for (int i = 1; i < W; i++) begin
        tick();
        if (i == 2) begin start = 1'b0; a = ~a; b = 8'(op * 37 + 5); sub = ~sub; end
        if (i == 3) start = 1'b1;
        if (i == 5) start = (op < 2);
      end
      check($sformatf("b2b%0d.no_done_early", op), {31'd0, done}, 0);
      tick();
      check($sformatf("b2b%0d.done", op), {31'd0, done}, 1);
      check($sformatf("b2b%0d.sum", op), {24'd0, sum}, {24'd0, bes[op]});
      check($sformatf("b2b%0d.cout", op), {31'd0, cout}, {31'd0, bec[op]});
      check_ovf($sformatf("b2b%0d.ovf", op), beo[op]);
      if (op < 2) begin
        a = ba[op+1]; b = bb[op+1]; sub = bs[op+1];
      end
      tick();
    end
    check("b2b.end_idle", {30'd0, busy, done}, 0);

    // Reset while RUN with cnt=4 clears everything at once.
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort.busy_before", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort.busy", {31'd0, busy}, 0);
    check("abort.done", {31'd0, done}, 0);
    check("abort.sum", {24'd0, sum}, 0);
    check("abort.cout", {31'd0, cout}, 0);
    check_ovf("abort.ovf", 1'b0);
    tick();
    rst = 1'b0;
    tick();
    run_op("post_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Idle hold: results stay, no done pulses.
    begin
      int done_seen = 0;
      int sum_bad = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        done_seen += int'(done);
        sum_bad   += int'(sum !== 8'h03 || cout !== 1'b0);
      end
      check("idle.done_count", done_seen, 0);
      check("idle.result_changes", sum_bad, 0);
      check("idle.sum", {24'd0, sum}, 8'h03);
      check_ovf("idle.ovf", 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
